// File: rtl/skid_arb.sv
// Round-robin arbiter feeding a registered main/skid output stage; beats carry their source index.
// Optional burst lock is compiled in with SKID_ARB_LOCK_EN.
module skid_arb #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int SRC_W   = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        i_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0] i_data_i,
`ifdef SKID_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        i_last_i,
`endif
  output logic [NUM_REQ-1:0]        i_ready_o,
  input  logic                      e_ready_i,
  output logic                      e_valid_o,
  output logic [DATA_W-1:0]         e_data_o,
  output logic [SRC_W-1:0]          e_src_o
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [SRC_W-1:0]  main_src_q, main_src_d, skid_src_q, skid_src_d;
  logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
`ifdef SKID_ARB_LOCK_EN
  logic              lock_q, lock_d;
  logic [SRC_W-1:0]  lock_id_q, lock_id_d;
`endif

  logic              found, acc, pop;
  logic [SRC_W-1:0]  sel, sel_next;
  logic [DATA_W-1:0] new_data;

  // Ready is built only from registered state and i_valid_i, never e_ready_i.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int idx;
      logic elig;
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
`ifdef SKID_ARB_LOCK_EN
      elig = !lock_q || (lock_id_q == SRC_W'(idx));
`else
      elig = 1'b1;
`endif
      if (!found && i_valid_i[idx] && elig) begin
        found = 1'b1;
        sel   = SRC_W'(idx);
      end
    end
    acc       = found && (state_q != FULL) && reset_n;
    i_ready_o = acc ? (NUM_REQ'(1) << sel) : '0;
    new_data  = i_data_i[int'(sel)*DATA_W +: DATA_W];
    sel_next  = (int'(sel) == NUM_REQ-1) ? '0 : sel + SRC_W'(1);
    pop       = (state_q != EMPTY) && e_ready_i;
  end

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_src_d  = main_src_q;
    skid_data_d = skid_data_q;
    skid_src_d  = skid_src_q;
    rr_ptr_d    = rr_ptr_q;
`ifdef SKID_ARB_LOCK_EN
    lock_d      = lock_q;
    lock_id_d   = lock_id_q;
`endif
    case (state_q)
      EMPTY: if (acc) begin
        state_d     = ONE;
        main_data_d = new_data;
        main_src_d  = sel;
      end
      ONE: begin
        if (acc && !pop) begin
          state_d     = FULL;
          skid_data_d = new_data;
          skid_src_d  = sel;
        end else if (pop && !acc) begin
          state_d = EMPTY;
        end else if (acc && pop) begin
          main_data_d = new_data;
          main_src_d  = sel;
        end
      end
      FULL: if (pop) begin
        state_d     = ONE;
        main_data_d = skid_data_q;
        main_src_d  = skid_src_q;
      end
      default: state_d = EMPTY;
    endcase
`ifdef SKID_ARB_LOCK_EN
    // The pointer only moves when a burst closes.
    if (acc) begin
      if (i_last_i[sel]) begin
        lock_d   = 1'b0;
        rr_ptr_d = sel_next;
      end else begin
        lock_d    = 1'b1;
        lock_id_d = sel;
      end
    end
`else
    if (acc) rr_ptr_d = sel_next;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_src_q  <= '0;
      skid_data_q <= '0;
      skid_src_q  <= '0;
      rr_ptr_q    <= '0;
`ifdef SKID_ARB_LOCK_EN
      lock_q      <= 1'b0;
      lock_id_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_src_q  <= main_src_d;
      skid_data_q <= skid_data_d;
      skid_src_q  <= skid_src_d;
      rr_ptr_q    <= rr_ptr_d;
`ifdef SKID_ARB_LOCK_EN
      lock_q      <= lock_d;
      lock_id_q   <= lock_id_d;
`endif
    end
  end

  assign e_valid_o = (state_q != EMPTY);
  assign e_data_o  = main_data_q;
  assign e_src_o   = main_src_q;

endmodule

// File: doc/skid_arb.md
# skid_arb

Round-robin arbiter that shares one downstream skid-buffered valid/ready channel between `NUM_REQ` upstream requesters. Each cycle it grants at most one valid requester, captures that beat into a two-entry main/skid output stage, and tags it with the source index. `e_ready_i` never reaches `i_ready_o` combinationally, so the downstream ready path is fully registered. The block sits between the ingress sources and the shared egress consumer.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `DATA_W`, 8: beat width.
- `SRC_W`, 2: width of the source tag, equal to clog2(`NUM_REQ`).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `i_valid_i`  in  NUM_REQ  per-requester valid.
- `i_data_i`  in  NUM_REQ*DATA_W  requester k occupies bits [k*DATA_W +: DATA_W].
- `i_last_i`  in  NUM_REQ  end-of-burst marker. Present only with `SKID_ARB_LOCK_EN`.
- `i_ready_o`  out  NUM_REQ  one-hot or zero; beat k is accepted when `i_valid_i[k] & i_ready_o[k]`.
- `e_ready_i`  in  1  downstream ready.
- `e_valid_o`  out  1  registered output valid.
- `e_data_o`  out  DATA_W  registered output data.
- `e_src_o`  out  SRC_W  index of the requester that supplied the current beat.

## Operation
- Output stage FSM:
  - EMPTY: main register empty.
  - ONE: main register full.
  - FULL: main and skid registers both full.
- Definitions: `acc` = any accepted input beat; `pop` = `e_valid_o & e_ready_i`.
- Transitions:
  - EMPTY: `acc` -> ONE, main is loaded.
  - ONE: `acc & !pop` -> FULL, skid is loaded. `pop & !acc` -> EMPTY. `acc & pop` -> ONE, main is reloaded with the new beat.
  - FULL: `pop` -> ONE, main takes the skid contents. No accept is possible in FULL.
- `e_valid_o` = state != EMPTY. The skid register stores its own data and source tag.
- Arbitration (combinational):
  - Search from `rr_ptr_q` upward, wrapping from `NUM_REQ-1` to 0.
  - The first requester with `i_valid_i` set is selected.
  - `i_ready_o` = one-hot(selected) when state is not FULL and `reset_n` is high; otherwise 0.
- Pointer: on `acc` from requester k, `rr_ptr_q` <= (k+1) mod `NUM_REQ`. With no accept, the pointer holds.
- Combinational paths: `i_valid_i` -> `i_ready_o` is allowed. `e_ready_i` -> `i_ready_o` is forbidden; `i_ready_o` depends only on registered state.
- Ordering: beats leave in acceptance order. Within a single requester the order is preserved.
- Reset, asynchronous, including mid-transfer:
  - State returns to EMPTY and any held beats are discarded.
  - `e_valid_o`=0, `e_data_o`=0, `e_src_o`=0, `rr_ptr_q`=0, lock cleared.
  - `i_ready_o`=0 while `reset_n` is low.

## Timing
- Latency: a beat accepted at edge N is visible on `e_valid_o`/`e_data_o` after edge N, i.e. 1 cycle.
- Throughput: 1 beat/cycle with `e_ready_i` held high.
- Stall: when `e_ready_i` drops, one more beat is absorbed into the skid register. `i_ready_o` is all zero from the following cycle.
- Recovery: the first cycle with `e_ready_i` high pops main and moves skid into main (FULL -> ONE). Ready reasserts in the next cycle.
- Fairness: with all requesters continuously valid and no stall, grants rotate 0,1,…,NUM_REQ-1,0. Worst-case wait is `NUM_REQ-1` accepted beats.
- A requester dropping `i_valid_i` without being accepted is legal and has no effect on the pointer.

## Configuration
- `SKID_ARB_LOCK_EN` defined: burst lock.
  - Accepting a beat from k with `i_last_i[k]`=0 sets `lock_q` and records `lock_id_q`=k.
  - While locked, only requester k can be granted. If k is idle, bubbles occur; other requesters are not granted.
  - Accepting a beat from k with `i_last_i[k]`=1 clears the lock and advances the pointer to k+1.
  - The pointer does not advance on locked non-last beats.
- Not defined: `i_last_i` port is absent. Every beat is arbitrated independently.

## Test plan
- Reset then idle: `reset_n`=0 mid-FULL -> `e_valid_o`=0, `e_data_o`=0x00, `i_ready_o`=0000. After release with all requesters idle -> outputs hold 0.
- Single requester: req2 streams 0x10..0x13 with `e_ready_i`=1 -> `e_data_o` 0x10..0x13 on consecutive cycles, 1 cycle after each accept; `e_src_o`=2.
- Round robin: all four valid, data = 0xA0+k, `e_ready_i`=1 -> `e_src_o` sequence 0,1,2,3,0,1. No requester is granted twice before the others.
- Stall/skid: req0 streams 0x01,0x02,0x03. `e_ready_i` drops the cycle after 0x01 appears -> 0x02 lands in skid, `i_ready_o`=0000, 0x03 is held upstream. Releasing `e_ready_i` yields output 0x01,0x02,0x03 with none lost or duplicated.
- Simultaneous accept and pop in ONE: state stays ONE and main is replaced with the new beat on the same edge.
- `SKID_ARB_LOCK_EN`: req1 sends 3 beats with last on the 3rd while req0 is continuously valid -> `e_src_o` = 1,1,1,0. With req1 idle for 2 cycles mid-burst -> 2 bubbles and no grant to req0.
